// File: rtl/cola_dispense_sched.sv
// cola_dispense_sched: two-channel cola / change-return dispense scheduler.
// Four saturating pending counters (cola0, cola1, chg0, chg1) feed a single
// FSM that drives one actuator at a time: IDLE -> DISP_COLA/DISP_CHG -> GAP.
// A cola job whose channel also has change pending runs both phases back to
// back and emits a single done pulse. All outputs come straight from flops,
// so every output trails the FSM state by one cycle.
// Build option: define SCHED_ROUND_ROBIN_EN for round-robin arbitration
// between the two channels; when undefined, channel 0 has fixed priority and
// no pointer register is built.
module cola_dispense_sched #(
  parameter int unsigned DISP_CYC = 8,
  parameter int unsigned GAP_CYC  = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic sys_clk,
  input  logic sys_rst,
  input  logic pi_cola_req0,
  input  logic pi_cola_req1,
  input  logic pi_change_req0,
  input  logic pi_change_req1,
  output logic po_motor_cola,
  output logic po_motor_change,
  output logic po_done0,
  output logic po_done1,
  output logic po_busy,
  output logic po_ovf
);

  localparam int unsigned CYC_MAX = (DISP_CYC > GAP_CYC) ? DISP_CYC : GAP_CYC;
  localparam int unsigned CYC_W   = $clog2(CYC_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CYC_W-1:0] DISP_LOAD = CYC_W'(DISP_CYC - 1);
  localparam logic [CYC_W-1:0] GAP_LOAD  = CYC_W'(GAP_CYC - 1);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DISP_COLA = 2'd1,
    ST_DISP_CHG  = 2'd2,
    ST_GAP       = 2'd3
  } state_e;

  // FSM state and per-job bookkeeping
  state_e           state_q, state_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             chan_q, chan_d;
  logic             gap_exit_q, gap_exit_d;
`ifdef SCHED_ROUND_ROBIN_EN
  logic             ptr_q, ptr_d;
`endif

  // Pending counters, indexed by channel
  logic [CNT_W-1:0] cola_cnt_q [2];
  logic [CNT_W-1:0] cola_cnt_d [2];
  logic [CNT_W-1:0] chg_cnt_q  [2];
  logic [CNT_W-1:0] chg_cnt_d  [2];
  logic             ovf_q, ovf_d;

  // Registered outputs
  logic motor_cola_q,   motor_cola_d;
  logic motor_change_q, motor_change_d;
  logic done0_q,        done0_d;
  logic done1_q,        done1_d;
  logic busy_q,         busy_d;

  // Request / grant strobes per channel and arbitration result
  logic [1:0] inc_cola;
  logic [1:0] inc_chg;
  logic [1:0] dec_cola;
  logic [1:0] dec_chg;
  logic [1:0] pend;
  logic       pick;

  assign inc_cola = {pi_cola_req1, pi_cola_req0};
  assign inc_chg  = {pi_change_req1, pi_change_req0};

  // A channel has work if either of its counters is nonzero
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      pend[i] = (cola_cnt_q[i] != '0) || (chg_cnt_q[i] != '0);
    end
  end

  // Channel selection for the next IDLE grant
  always_comb begin
`ifdef SCHED_ROUND_ROBIN_EN
    if (pend == 2'b11) begin
      pick = ptr_q;
    end else begin
      pick = ~pend[0];
    end
`else
    pick = ~pend[0];
`endif
  end

  // FSM state register
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: transitions, cycle-counter reloads and grant strobes
  always_comb begin
    state_d    = state_q;
    cyc_d      = cyc_q;
    chan_d     = chan_q;
    gap_exit_d = 1'b0;
    dec_cola   = '0;
    dec_chg    = '0;
`ifdef SCHED_ROUND_ROBIN_EN
    ptr_d      = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend != 2'b00) begin
          chan_d = pick;
          cyc_d  = DISP_LOAD;
`ifdef SCHED_ROUND_ROBIN_EN
          ptr_d  = ~pick;
`endif
          if (cola_cnt_q[pick] != '0) begin
            dec_cola[pick] = 1'b1;
            state_d        = ST_DISP_COLA;
          end else begin
            dec_chg[pick] = 1'b1;
            state_d       = ST_DISP_CHG;
          end
        end
      end
      ST_DISP_COLA: begin
        if (cyc_q == '0) begin
          if (chg_cnt_q[chan_q] != '0) begin
            dec_chg[chan_q] = 1'b1;
            state_d         = ST_DISP_CHG;
            cyc_d           = DISP_LOAD;
          end else begin
            state_d = ST_GAP;
            cyc_d   = GAP_LOAD;
          end
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      ST_DISP_CHG: begin
        if (cyc_q == '0) begin
          state_d = ST_GAP;
          cyc_d   = GAP_LOAD;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      ST_GAP: begin
        if (cyc_q == '0) begin
          state_d    = ST_IDLE;
          cyc_d      = '0;
          gap_exit_d = 1'b1;
        end else begin
          cyc_d = cyc_q - CYC_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cyc_d   = '0;
      end
    endcase
  end

  // Output logic: every output is a function of the current registered state
  always_comb begin
    motor_cola_d   = (state_q == ST_DISP_COLA);
    motor_change_d = (state_q == ST_DISP_CHG);
    busy_d         = (state_q != ST_IDLE);
    done0_d        = gap_exit_q & ~chan_q;
    done1_d        = gap_exit_q &  chan_q;
  end

  // Saturating counters: simultaneous request and grant cancel out
  always_comb begin
    ovf_d = ovf_q;
    for (int i = 0; i < 2; i++) begin
      cola_cnt_d[i] = cola_cnt_q[i];
      chg_cnt_d[i]  = chg_cnt_q[i];
      if (inc_cola[i] && !dec_cola[i]) begin
        if (cola_cnt_q[i] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          cola_cnt_d[i] = cola_cnt_q[i] + CNT_W'(1);
        end
      end else if (!inc_cola[i] && dec_cola[i]) begin
        cola_cnt_d[i] = cola_cnt_q[i] - CNT_W'(1);
      end
      if (inc_chg[i] && !dec_chg[i]) begin
        if (chg_cnt_q[i] == CNT_MAX) begin
          ovf_d = 1'b1;
        end else begin
          chg_cnt_d[i] = chg_cnt_q[i] + CNT_W'(1);
        end
      end else if (!inc_chg[i] && dec_chg[i]) begin
        chg_cnt_d[i] = chg_cnt_q[i] - CNT_W'(1);
      end
    end
  end

  // Datapath and output registers; reset abandons any job in flight
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cyc_q          <= '0;
      chan_q         <= 1'b0;
      gap_exit_q     <= 1'b0;
`ifdef SCHED_ROUND_ROBIN_EN
      ptr_q          <= 1'b0;
`endif
      for (int i = 0; i < 2; i++) begin
        cola_cnt_q[i] <= '0;
        chg_cnt_q[i]  <= '0;
      end
      ovf_q          <= 1'b0;
      motor_cola_q   <= 1'b0;
      motor_change_q <= 1'b0;
      done0_q        <= 1'b0;
      done1_q        <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      cyc_q          <= cyc_d;
      chan_q         <= chan_d;
      gap_exit_q     <= gap_exit_d;
`ifdef SCHED_ROUND_ROBIN_EN
      ptr_q          <= ptr_d;
`endif
      for (int i = 0; i < 2; i++) begin
        cola_cnt_q[i] <= cola_cnt_d[i];
        chg_cnt_q[i]  <= chg_cnt_d[i];
      end
      ovf_q          <= ovf_d;
      motor_cola_q   <= motor_cola_d;
      motor_change_q <= motor_change_d;
      done0_q        <= done0_d;
      done1_q        <= done1_d;
      busy_q         <= busy_d;
    end
  end

  assign po_motor_cola   = motor_cola_q;
  assign po_motor_change = motor_change_q;
  assign po_done0        = done0_q;
  assign po_done1        = done1_q;
  assign po_busy         = busy_q;
  assign po_ovf          = ovf_q;

endmodule

// File: tb/tb_cola_dispense_sched.sv
// Self-checking bench for cola_dispense_sched: directed scenarios plus
// randomized traffic compared cycle by cycle against a job-level model.
module tb_cola_dispense_sched;

  localparam int DISP = 8;
  localparam int GAP  = 4;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;
`ifdef SCHED_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst;
  logic cola_req0, cola_req1, chg_req0, chg_req1;
  logic po_motor_cola, po_motor_change, po_done0, po_done1, po_busy, po_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  cola_dispense_sched #(.DISP_CYC(DISP), .GAP_CYC(GAP), .CNT_W(CW)) dut (
    .sys_clk        (clk),
    .sys_rst        (rst),
    .pi_cola_req0   (cola_req0),
    .pi_cola_req1   (cola_req1),
    .pi_change_req0 (chg_req0),
    .pi_change_req1 (chg_req1),
    .po_motor_cola  (po_motor_cola),
    .po_motor_change(po_motor_change),
    .po_done0       (po_done0),
    .po_done1       (po_done1),
    .po_busy        (po_busy),
    .po_ovf         (po_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: pending job counts and the job in progress.
  // m_cnt index: 0 cola0, 1 cola1, 2 chg0, 3 chg1.
  // m_phase: 0 idle, 1 pouring cola, 2 returning change, 3 gap.
  int         m_cnt [4];
  int         m_phase, m_left, m_ch, m_last;
  logic       m_ovf;
  logic       m_done_pend;
  int         m_done_ch;
  logic [5:0] exp_vec;

  function automatic logic [5:0] obs();
    return {po_motor_cola, po_motor_change, po_done0, po_done1, po_busy, po_ovf};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_phase = 0; m_left = 0; m_ch = 0; m_last = 1;
    m_ovf = 1'b0; m_done_pend = 1'b0; m_done_ch = 0;
    exp_vec = '0;
  endtask

  // Advance the model by one clock; outputs seen after the edge reflect
  // the job phase before the edge.
  task automatic model_step(input logic c0, input logic c1, input logic h0, input logic h1);
    logic [3:0] req;
    logic [3:0] dec;
    logic p0, p1;
    int ch;
    req = {h1, h0, c1, c0};
    dec = '0;
    exp_vec = {m_phase == 1, m_phase == 2, m_done_pend && (m_done_ch == 0),
               m_done_pend && (m_done_ch == 1), m_phase != 0, 1'b0};
    m_done_pend = 1'b0;
    case (m_phase)
      0: begin
        p0 = (m_cnt[0] + m_cnt[2]) > 0;
        p1 = (m_cnt[1] + m_cnt[3]) > 0;
        if (p0 || p1) begin
          if (p0 && p1) ch = RR ? 1 - m_last : 0;
          else          ch = p0 ? 0 : 1;
          m_ch = ch; m_last = ch; m_left = DISP;
          if (m_cnt[ch] > 0) begin dec[ch] = 1'b1; m_phase = 1; end
          else begin dec[2 + ch] = 1'b1; m_phase = 2; end
        end
      end
      1: begin
        m_left--;
        if (m_left == 0) begin
          if (m_cnt[2 + m_ch] > 0) begin
            dec[2 + m_ch] = 1'b1; m_phase = 2; m_left = DISP;
          end else begin
            m_phase = 3; m_left = GAP;
          end
        end
      end
      2: begin
        m_left--;
        if (m_left == 0) begin m_phase = 3; m_left = GAP; end
      end
      default: begin
        m_left--;
        if (m_left == 0) begin m_phase = 0; m_done_pend = 1'b1; m_done_ch = m_ch; end
      end
    endcase
    for (int i = 0; i < 4; i++) begin
      if (req[i] && !dec[i]) begin
        if (m_cnt[i] == CMAX) m_ovf = 1'b1;
        else m_cnt[i]++;
      end else if (!req[i] && dec[i]) begin
        m_cnt[i]--;
      end
    end
    exp_vec[0] = m_ovf;
  endtask

  // Drive one cycle of request pulses, clock it and update the model
  task automatic tick(input logic c0, input logic c1, input logic h0, input logic h1);
    cola_req0 = c0; cola_req1 = c1; chg_req0 = h0; chg_req1 = h1;
    @(posedge clk);
    if (rst) model_reset();
    else model_step(c0, c1, h0, h1);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if (obs() !== 6'b0) begin
      n_errors++; $display("FAIL reset_async got=%b exp=%b", obs(), 6'b0);
    end
    model_reset();
    tick(1, 1, 1, 1);
    n_checks++;
    if (obs() !== 6'b0) begin
      n_errors++; $display("FAIL reset_hold got=%b exp=%b", obs(), 6'b0);
    end
    tick(1, 0, 1, 0);
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_vec || po_busy !== 1'b0) begin
        n_errors++; $display("FAIL reset_ignored cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
    end
  endtask

  task automatic test_single();
    int first, last, hi, done_at, busy_low;
    first = -1; last = -1; hi = 0; done_at = -1; busy_low = -1;
    do_reset();
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL single_model cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (po_motor_cola) begin if (first < 0) first = i; last = i; hi++; end
      if (po_done0 && done_at < 0) done_at = i;
      if (!po_busy && first >= 0 && busy_low < 0) busy_low = i;
    end
    n_checks++;
    if (first !== 2 || last !== 9 || hi !== 8) begin
      n_errors++; $display("FAIL single_motor got first=%0d last=%0d n=%0d exp 2 9 8", first, last, hi);
    end
    n_checks++;
    if (done_at !== 14 || busy_low !== 14) begin
      n_errors++; $display("FAIL single_done got done=%0d busylow=%0d exp 14 14", done_at, busy_low);
    end
  endtask

  task automatic test_combo();
    int cola_hi, chg_hi, cola_last, chg_first, chg_last, d0, d1, d1_at, both;
    cola_hi = 0; chg_hi = 0; cola_last = -1; chg_first = -1; chg_last = -1;
    d0 = 0; d1 = 0; d1_at = -1; both = 0;
    do_reset();
    tick(0, 1, 0, 1);
    for (int i = 1; i <= 40; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL combo_model cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (po_motor_cola) begin cola_hi++; cola_last = i; end
      if (po_motor_change) begin chg_hi++; if (chg_first < 0) chg_first = i; chg_last = i; end
      if (po_motor_cola && po_motor_change) both++;
      if (po_done0) d0++;
      if (po_done1) begin d1++; d1_at = i; end
    end
    n_checks++;
    if (cola_hi !== 8 || chg_hi !== 8 || chg_first !== cola_last + 1 || both !== 0) begin
      n_errors++;
      $display("FAIL combo_motors got cola=%0d chg=%0d gap=%0d both=%0d exp 8 8 1 0",
               cola_hi, chg_hi, chg_first - cola_last, both);
    end
    n_checks++;
    if (d1 !== 1 || d0 !== 0 || d1_at !== chg_last + GAP + 1) begin
      n_errors++; $display("FAIL combo_done got d1=%0d d0=%0d at=%0d exp 1 0 %0d",
                           d1, d0, d1_at, chg_last + GAP + 1);
    end
  endtask

  task automatic test_order();
    int got [$];
    int exp_order [6];
    if (RR) exp_order = '{0, 1, 0, 1, 0, 1};
    else    exp_order = '{0, 0, 0, 1, 1, 1};
    do_reset();
    for (int i = 0; i < 3; i++) tick(1, 1, 0, 0);
    for (int i = 0; i < 400 && got.size() < 6; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL order_model cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (po_done0) got.push_back(0);
      if (po_done1) got.push_back(1);
    end
    n_checks++;
    if (got.size() != 6) begin
      n_errors++; $display("FAIL order_timeout got %0d dones exp 6", got.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_checks++;
        if (got[i] !== exp_order[i]) begin
          n_errors++; $display("FAIL order_%0d got ch=%0d exp ch=%0d", i, got[i], exp_order[i]);
        end
      end
    end
  endtask

  task automatic test_ovf();
    int d0, d1;
    d0 = 0; d1 = 0;
    do_reset();
    tick(0, 1, 0, 0);
    tick(0, 0, 0, 0);
    tick(0, 0, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      tick(1, 0, 0, 0);
      n_checks++;
      if (po_ovf !== (k >= 8) || obs() !== exp_vec) begin
        n_errors++; $display("FAIL ovf_pulse%0d got ovf=%b vec=%b exp ovf=%b vec=%b",
                             k, po_ovf, obs(), k >= 8, exp_vec);
      end
    end
    for (int i = 0; i < 200; i++) begin
      tick(0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL ovf_model cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (po_done0) d0++;
      if (po_done1) d1++;
    end
    n_checks++;
    if (d0 !== 7 || d1 !== 1 || po_ovf !== 1'b1) begin
      n_errors++; $display("FAIL ovf_jobs got d0=%0d d1=%0d ovf=%b exp 7 1 1", d0, d1, po_ovf);
    end
  endtask

  task automatic test_reset_mid();
    int bad, hi, done_at;
    bad = 0; hi = 0; done_at = -1;
    do_reset();
    tick(1, 0, 0, 0);
    tick(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
    n_checks++;
    if (po_motor_cola !== 1'b1) begin
      n_errors++; $display("FAIL mid_pre got motor=%b exp 1", po_motor_cola);
    end
    rst = 1'b1;
    model_reset();
    #1;
    n_checks++;
    if (obs() !== 6'b0) begin
      n_errors++; $display("FAIL mid_async got=%b exp=%b", obs(), 6'b0);
    end
    tick(1, 1, 1, 1);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick(0, 0, 0, 0);
      if (po_busy || po_done0 || po_done1 || po_motor_cola) bad++;
    end
    n_checks++;
    if (bad !== 0) begin
      n_errors++; $display("FAIL mid_idle got %0d active cycles exp 0", bad);
    end
    tick(1, 0, 0, 0);
    for (int i = 1; i <= 20; i++) begin
      tick(0, 0, 0, 0);
      if (po_motor_cola) hi++;
      if (po_done0 && done_at < 0) done_at = i;
    end
    n_checks++;
    if (hi !== 8 || done_at !== 14) begin
      n_errors++; $display("FAIL mid_after got motor=%0d done=%0d exp 8 14", hi, done_at);
    end
  endtask

  task automatic test_same_cycle();
    int d0;
    d0 = 0;
    do_reset();
    for (int i = 0; i <= 60; i++) begin
      // pulses at the first request edge and at each of the two grant edges
      tick((i == 0 || i == 1 || i == 14) ? 1'b1 : 1'b0, 0, 0, 0);
      n_checks++;
      if (obs() !== exp_vec) begin
        n_errors++; $display("FAIL same_model cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if (po_done0) d0++;
    end
    n_checks++;
    if (d0 !== 3) begin
      n_errors++; $display("FAIL same_jobs got %0d exp 3", d0);
    end
  endtask

  task automatic test_random();
    int rate;
    logic c0, c1, h0, h1;
    rate = 8;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) rate = int'($urandom_range(30, 3));
      c0 = ($urandom_range(rate - 1) == 0);
      c1 = ($urandom_range(rate - 1) == 0);
      h0 = ($urandom_range(rate + 2) == 0);
      h1 = ($urandom_range(rate + 2) == 0);
      tick(c0, c1, h0, h1);
      n_checks++;
      if (obs() !== exp_vec || (po_motor_cola && po_motor_change)) begin
        n_errors++; $display("FAIL rand_model cyc=%0d got=%b exp=%b", cyc, obs(), exp_vec);
      end
      if ($urandom_range(399) == 0) begin
        rst = 1'b1;
        model_reset();
        #1;
        n_checks++;
        if (obs() !== 6'b0) begin
          n_errors++; $display("FAIL rand_reset cyc=%0d got=%b exp=%b", cyc, obs(), 6'b0);
        end
        tick(1, 1, 1, 1);
        rst = 1'b0;
      end
    end
  endtask

  initial begin
    cola_req0 = 1'b0; cola_req1 = 1'b0; chg_req0 = 1'b0; chg_req1 = 1'b0;
    rst = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    test_reset();
    test_single();
    test_combo();
    test_order();
    test_ovf();
    test_reset_mid();
    test_same_cycle();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
